// File: rtl/nmr_bstrm_pkg.sv
// Shared types and constants for the NMR bitstream pulse datapath.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package nmr_bstrm_pkg;

  localparam int BSTRM_DATA_WIDTH = 24;
  localparam int BSTRM_MUX_WIDTH  = 16;

  // Level driven on OUT whenever no segment is playing.
  localparam logic IDLE_LEVEL = 1'b0;

  // Shortest segment that still covers the controller's RDY-to-START turnaround.
  localparam int MIN_SEG_LEN = 7;

  typedef struct packed {
    logic                        pol;
    logic [3:0]                  sel;
    logic [BSTRM_DATA_WIDTH-1:0] len;
  } bstrm_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dpath_state_t;

endpackage

// File: rtl/nmr_bstrm_seg_cnt.sv
// Loadable segment down-counter; tc marks the last cycle of a segment.
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; stops at 0 and only leaves it on a load.
module nmr_bstrm_seg_cnt #(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Load len-1 (a zero length plays as one cycle), otherwise count down to 0 and hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (len == '0) ? '0 : len - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nmr_bstrm_pulse_dpath.sv
// Bitstream pulse datapath: active/shadow command buffer playing segments back-to-back on OUT.
// Latency: OUT shows a segment 1 cycle after it enters the active slot, for max(len,1) cycles.
// Backpressure: DPATH_RDY pulses when the shadow frees up; a START into a full shadow is dropped and flags OVERRUN.
module nmr_bstrm_pulse_dpath
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = BSTRM_DATA_WIDTH,
  parameter int MUX_WIDTH  = BSTRM_MUX_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PLS_POL,
  input  logic [3:0]            mux_sel,
  input  logic [MUX_WIDTH-2:0]  mux_in,
  output logic                  OUT,
  output logic                  DPATH_RDY,
  output logic                  BUSY,
  output logic                  OVERRUN,
  input  logic                  ERR_CLR
);

  dpath_state_t            state;
  bstrm_cmd_t              new_cmd;
  bstrm_cmd_t              shd_cmd;
  logic                    shd_vld;
  logic                    act_pol;
  logic [3:0]              act_sel;
  logic                    out_q;
  logic                    rdy_q;
  logic                    busy_q;
  logic                    ovr_q;
  logic                    tc;
  logic                    seg_end;
  logic                    take_new;
  logic                    take_shd;
  logic                    fill_shd;
  logic                    drop;
  logic                    src_bit;
  logic                    cnt_load;
  logic [DATA_WIDTH-1:0]   cnt_len;

  assign new_cmd = '{pol: PLS_POL, sel: mux_sel, len: data};

  // Decide where an incoming START lands and whether the active slot reloads this cycle.
  always_comb begin
    seg_end  = (state == RUN) && tc;
    take_new = START && ((state == IDLE) || (seg_end && !shd_vld));
    take_shd = seg_end && shd_vld;
    fill_shd = START && (state == RUN) && (shd_vld ? tc : !tc);
    drop     = START && (state == RUN) && shd_vld && !tc;
  end

  assign cnt_load = take_new | take_shd;
  assign cnt_len  = take_shd ? shd_cmd.len : new_cmd.len;

  nmr_bstrm_seg_cnt #(
    .W (DATA_WIDTH)
  ) u_seg_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (cnt_load),
    .len  (cnt_len),
    .tc   (tc)
  );

  // Source bit for the active segment; selects outside the mux range fall back to the static level.
  always_comb begin
    src_bit = act_pol;
    if ((act_sel != 4'd0) && (int'(act_sel) < MUX_WIDTH)) begin
      src_bit = mux_in[act_sel - 4'd1] ^ ~act_pol;
    end
  end

  // Playback FSM with command buffer and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      shd_cmd <= '0;
      shd_vld <= 1'b0;
      act_pol <= 1'b0;
      act_sel <= 4'd0;
      out_q   <= IDLE_LEVEL;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Shadow refilled in the same cycle it drains stays full, so no RDY then.
      // Suppressing back-to-back pulses keeps RDY a clean single-cycle strobe.
      rdy_q <= (take_new || (take_shd && !START)) && !rdy_q;

      if (drop) begin
        ovr_q <= 1'b1;
      end else if (ERR_CLR) begin
        ovr_q <= 1'b0;
      end

      if (fill_shd) begin
        shd_cmd <= new_cmd;
        shd_vld <= 1'b1;
      end else if (take_shd) begin
        shd_vld <= 1'b0;
      end

      if (take_new) begin
        act_pol <= new_cmd.pol;
        act_sel <= new_cmd.sel;
      end else if (take_shd) begin
        act_pol <= shd_cmd.pol;
        act_sel <= shd_cmd.sel;
      end

      case (state)
        IDLE: begin
          out_q <= IDLE_LEVEL;
          if (START) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          out_q <= src_bit;
          if (seg_end && !shd_vld && !START) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign OUT       = out_q;
  assign DPATH_RDY = rdy_q;
  assign BUSY      = busy_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_nmr_bstrm_pulse_dpath.sv
// Directed bench for the bitstream pulse datapath.
// Latency: cycle index c=0 is the cycle right after the edge that samples START.
// Backpressure: commands are issued on fixed cycle offsets relative to observed RDY.
module tb_nmr_bstrm_pulse_dpath;

  localparam int DW = 24;
  localparam int MW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [DW-1:0] data = '0;
  logic          PLS_POL = 1'b0;
  logic [3:0]    mux_sel = 4'd0;
  logic [MW-2:0] mux_in = '0;
  logic          OUT;
  logic          DPATH_RDY;
  logic          BUSY;
  logic          OVERRUN;
  logic          ERR_CLR = 1'b0;

  int checks = 0;
  int failures = 0;

  nmr_bstrm_pulse_dpath #(
    .DATA_WIDTH (DW),
    .MUX_WIDTH  (MW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .data      (data),
    .PLS_POL   (PLS_POL),
    .mux_sel   (mux_sel),
    .mux_in    (mux_in),
    .OUT       (OUT),
    .DPATH_RDY (DPATH_RDY),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .ERR_CLR   (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm(input int len, input logic pol, input logic [3:0] sel);
    data    = DW'(len);
    PLS_POL = pol;
    mux_sel = sel;
    START   = 1'b1;
  endtask

  task automatic send(input int len, input logic pol, input logic [3:0] sel);
    arm(len, pol, sel);
    step();
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL reset_out got=%b exp=0", OUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (DPATH_RDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", DPATH_RDY); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", OVERRUN); end
    #3 RST = 1'b0;
    step();
    step();
  endtask

  task automatic test_single();
    int rdy_n = 0, hi_n = 0, first = -1, last = -1;
    logic rdy0 = 1'b0, busy99 = 1'b0, busy100 = 1'b1;
    send(100, 1'b1, 4'd0);
    for (int c = 0; c <= 101; c++) begin
      if (DPATH_RDY) rdy_n++;
      if (OUT) begin
        hi_n++;
        if (first < 0) first = c;
        last = c;
      end
      if (c == 0) rdy0 = DPATH_RDY;
      if (c == 99) busy99 = BUSY;
      if (c == 100) busy100 = BUSY;
      step();
    end
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL single_rdy_after_load got=%b exp=1", rdy0); end
    checks++; if (rdy_n != 1) begin failures++; $display("FAIL single_rdy_count got=%0d exp=1", rdy_n); end
    checks++; if (hi_n != 100) begin failures++; $display("FAIL single_high_len got=%0d exp=100", hi_n); end
    checks++; if (first != 1) begin failures++; $display("FAIL single_first_high got=%0d exp=1", first); end
    checks++; if (last != 100) begin failures++; $display("FAIL single_last_high got=%0d exp=100", last); end
    checks++; if (busy99 !== 1'b1) begin failures++; $display("FAIL single_busy_c99 got=%b exp=1", busy99); end
    checks++; if (busy100 !== 1'b0) begin failures++; $display("FAIL single_busy_c100 got=%b exp=0", busy100); end
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL single_out_after got=%b exp=0", OUT); end
  endtask

  task automatic test_seq();
    int lens [3] = '{10, 7, 20};
    logic pols [3] = '{1'b1, 1'b0, 1'b1};
    int nxt = 1, sched = -1, rdy_n = 0;
    logic [37:0] obs = '0;
    logic [37:0] exp_v;
    exp_v = (38'hFFFFF << 17) | 38'h3FF;
    send(lens[0], pols[0], 4'd0);
    for (int c = 0; c <= 38; c++) begin
      if (c >= 1) obs[c-1] = OUT;
      if (DPATH_RDY) begin
        rdy_n++;
        sched = c + 3;
      end
      if (c == sched && nxt < 3) begin
        arm(lens[nxt], pols[nxt], 4'd0);
        nxt++;
      end else begin
        START = 1'b0;
      end
      step();
    end
    START = 1'b0;
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL seq_stream got=%h exp=%h", obs, exp_v); end
    checks++; if (rdy_n != 3) begin failures++; $display("FAIL seq_rdy_count got=%0d exp=3", rdy_n); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL seq_busy_end got=%b exp=0", BUSY); end
  endtask

  task automatic test_zero_len();
    send(0, 1'b1, 4'd0);
    checks++; if (DPATH_RDY !== 1'b1) begin failures++; $display("FAIL zero_rdy got=%b exp=1", DPATH_RDY); end
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL zero_busy_c0 got=%b exp=1", BUSY); end
    step();
    checks++; if (OUT !== 1'b1) begin failures++; $display("FAIL zero_out_c1 got=%b exp=1", OUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL zero_busy_c1 got=%b exp=0", BUSY); end
    step();
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL zero_out_c2 got=%b exp=0", OUT); end
    step();
  endtask

  task automatic test_mux();
    logic [19:0] pat = 20'b1011_0010_1110_0001_1010;
    logic [19:0] obs = '0;
    logic [19:0] exp_v;
    int hi_n = 0;
    exp_v = ~pat;
    send(20, 1'b0, 4'd3);
    for (int c = 0; c <= 20; c++) begin
      if (c >= 1) obs[c-1] = OUT;
      mux_in = '0;
      if (c < 20) mux_in[2] = pat[c];
      step();
    end
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL mux_sel3_inv got=%h exp=%h", obs, exp_v); end
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL mux_sel3_idle got=%b exp=0", OUT); end
    mux_in = 15'h4000;
    send(6, 1'b1, 4'd15);
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1 && c <= 6 && OUT === 1'b1) hi_n++;
      step();
    end
    mux_in = '0;
    checks++; if (hi_n != 6) begin failures++; $display("FAIL mux_sel15_level got=%0d exp=6", hi_n); end
  endtask

  task automatic test_overrun();
    logic [44:0] obs = '0;
    logic [44:0] exp_v = 45'h3FFF_FFFF;
    logic ovr6 = 1'b0, ovr7 = 1'b0, busy38 = 1'b1;
    int rdy_n = 0;
    send(30, 1'b1, 4'd0);
    for (int c = 0; c <= 45; c++) begin
      if (c >= 1) obs[c-1] = OUT;
      if (DPATH_RDY) rdy_n++;
      if (c == 6) ovr6 = OVERRUN;
      if (c == 7) ovr7 = OVERRUN;
      if (c == 38) busy38 = BUSY;
      START = 1'b0;
      ERR_CLR = 1'b0;
      if (c == 3) arm(8, 1'b0, 4'd0);
      if (c == 5) arm(12, 1'b1, 4'd0);
      if (c == 6) begin
        arm(12, 1'b1, 4'd0);
        ERR_CLR = 1'b1;
      end
      step();
    end
    START = 1'b0;
    ERR_CLR = 1'b0;
    checks++; if (ovr6 !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ovr6); end
    checks++; if (ovr7 !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", ovr7); end
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL ovr_stream got=%h exp=%h", obs, exp_v); end
    checks++; if (busy38 !== 1'b0) begin failures++; $display("FAIL ovr_busy_c38 got=%b exp=0", busy38); end
    checks++; if (rdy_n != 2) begin failures++; $display("FAIL ovr_rdy_count got=%0d exp=2", rdy_n); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs_a = '0;
    logic [12:0] obs_b = '0;
    logic rdy5 = 1'b0, busy5 = 1'b0, busy8 = 1'b1, rdy6 = 1'b1;
    int rdy_a = 0, rdy_b = 0;
    send(5, 1'b0, 4'd0);
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) obs_a[c-1] = OUT;
      if (DPATH_RDY) rdy_a++;
      if (c == 5) begin rdy5 = DPATH_RDY; busy5 = BUSY; end
      if (c == 8) busy8 = BUSY;
      START = 1'b0;
      if (c == 4) arm(3, 1'b1, 4'd0);
      step();
    end
    START = 1'b0;
    checks++; if (obs_a !== 10'h0E0) begin failures++; $display("FAIL b2b_seamless_stream got=%h exp=0e0", obs_a); end
    checks++; if (rdy5 !== 1'b1) begin failures++; $display("FAIL b2b_seamless_rdy got=%b exp=1", rdy5); end
    checks++; if (busy5 !== 1'b1) begin failures++; $display("FAIL b2b_seamless_busy got=%b exp=1", busy5); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL b2b_seamless_end got=%b exp=0", busy8); end
    checks++; if (rdy_a != 2) begin failures++; $display("FAIL b2b_seamless_rdy_count got=%0d exp=2", rdy_a); end
    send(6, 1'b1, 4'd0);
    for (int c = 0; c <= 13; c++) begin
      if (c >= 1) obs_b[c-1] = OUT;
      if (DPATH_RDY) rdy_b++;
      if (c == 6) rdy6 = DPATH_RDY;
      START = 1'b0;
      if (c == 2) arm(3, 1'b0, 4'd0);
      if (c == 5) arm(2, 1'b1, 4'd0);
      step();
    end
    START = 1'b0;
    checks++; if (obs_b !== 13'h063F) begin failures++; $display("FAIL b2b_full_stream got=%h exp=063f", obs_b); end
    checks++; if (rdy6 !== 1'b0) begin failures++; $display("FAIL b2b_full_no_rdy got=%b exp=0", rdy6); end
    checks++; if (rdy_b != 2) begin failures++; $display("FAIL b2b_full_rdy_count got=%0d exp=2", rdy_b); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL b2b_full_no_ovr got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_rst_mid();
    logic [6:0] obs = '0;
    send(100, 1'b1, 4'd0);
    for (int c = 0; c < 5; c++) step();
    checks++; if (OUT !== 1'b1) begin failures++; $display("FAIL rst_pre_out got=%b exp=1", OUT); end
    #2 RST = 1'b1;
    #1;
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL rst_async_out got=%b exp=0", OUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", BUSY); end
    checks++; if (DPATH_RDY !== 1'b0) begin failures++; $display("FAIL rst_async_rdy got=%b exp=0", DPATH_RDY); end
    #1 RST = 1'b0;
    step();
    step();
    checks++; if (OUT !== 1'b0) begin failures++; $display("FAIL rst_stays_idle got=%b exp=0", OUT); end
    send(4, 1'b1, 4'd0);
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1) obs[c-1] = OUT;
      step();
    end
    checks++; if (obs !== 7'h0F) begin failures++; $display("FAIL rst_replay_stream got=%h exp=0f", obs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_seq();
    test_zero_len();
    test_mux();
    test_overrun();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
